// File: rtl/param_addsub_acc.sv
// Sequential two-operand add/subtract datapath: operands are captured one at a
// time from a shared bus on load edges, with optional accumulation into the result.
module param_addsub_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             op,
  input  logic             acc_mode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_load_q;
  logic             r_op;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_valid;

  logic             w_event;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  assign w_event = load & ~r_load_q;

  // Subtract is A + ~B + 1, so carry is NOT borrow and overflow uses the inverted B.
  assign w_b_eff = r_op ? ~r_op_b : r_op_b;
  assign w_sum   = {1'b0, r_op_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_op};
  assign w_ovf   = (r_op_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_op_a[WIDTH-1]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_A;
      r_load_q   <= 1'b1;
      r_op       <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_load_q <= load;
      case (r_state)
        S_A: begin
          if (w_event) begin
            r_op_a  <= data_in;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (w_event) begin
            r_op_b  <= data_in;
            r_op    <= op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result   <= w_sum[WIDTH-1:0];
          r_carry    <= w_sum[WIDTH];
          r_overflow <= w_ovf;
          r_valid    <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (w_event) begin
            r_valid <= 1'b0;
            if (acc_mode) begin
              r_op_a  <= r_result;
              r_op_b  <= data_in;
              r_op    <= op;
              r_state <= S_EXEC;
            end else begin
              r_op_a  <= data_in;
              r_state <= S_B;
            end
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign valid    = r_valid;
  assign state    = r_state;

endmodule

// File: tb/tb_param_addsub_acc.sv
// Bench for param_addsub_acc: arithmetic reference model checked every cycle on
// the 8-bit instance, plus literal checks on 8- and 16-bit instances.
module tb_param_addsub_acc;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         op = 1'b0;
  logic         acc_mode = 1'b0;
  logic [W-1:0] op_a, op_b, result;
  logic         carry, overflow, valid;
  logic [1:0]   state;

  logic         load16 = 1'b0;
  logic [15:0]  data16 = '0;
  logic         op16 = 1'b0;
  logic         acc16 = 1'b0;
  logic [15:0]  op_a16, op_b16, result16;
  logic         carry16, overflow16, valid16;
  logic [1:0]   state16;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  param_addsub_acc #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .load(load), .data_in(data_in),
    .op(op), .acc_mode(acc_mode), .op_a(op_a), .op_b(op_b),
    .result(result), .carry(carry), .overflow(overflow),
    .valid(valid), .state(state)
  );

  param_addsub_acc #(.WIDTH(16)) dut16 (
    .clock(clock), .resetn(resetn), .load(load16), .data_in(data16),
    .op(op16), .acc_mode(acc16), .op_a(op_a16), .op_b(op_b16),
    .result(result16), .carry(carry16), .overflow(overflow16),
    .valid(valid16), .state(state16)
  );

  // ---------------- reference model ----------------
  // Phases: 0 = waiting A, 1 = waiting B, 2 = computing, 3 = done.
  int           m_phase;
  logic         m_prev_load;
  logic         m_op;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_c, m_v, m_valid;

  // Arithmetic from the definitions: unsigned range for carry, signed range for overflow.
  task automatic arith(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, s_res, modv;
    modv = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= modv / 2) ? ua - modv : ua;
    sb = (ub >= modv / 2) ? ub - modv : ub;
    if (o) begin
      r = W'((ua - ub + modv) % modv);
      c = (ua >= ub);
      s_res = sa - sb;
    end else begin
      r = W'((ua + ub) % modv);
      c = (ua + ub >= modv);
      s_res = sa + sb;
    end
    v = (s_res >= modv / 2) || (s_res < -(modv / 2));
  endtask

  always @(posedge clock or negedge resetn) begin
    logic [W-1:0] r;
    logic c, v, ev;
    if (!resetn) begin
      m_phase <= 0; m_prev_load <= 1'b1; m_op <= 1'b0;
      m_a <= '0; m_b <= '0; m_res <= '0;
      m_c <= 1'b0; m_v <= 1'b0; m_valid <= 1'b0;
    end else begin
      ev = load && !m_prev_load;
      m_prev_load <= load;
      if (m_phase == 0 && ev) begin
        m_a <= data_in; m_phase <= 1;
      end else if (m_phase == 1 && ev) begin
        m_b <= data_in; m_op <= op; m_phase <= 2;
      end else if (m_phase == 2) begin
        arith(m_a, m_b, m_op, r, c, v);
        m_res <= r; m_c <= c; m_v <= v; m_valid <= 1'b1; m_phase <= 3;
      end else if (m_phase == 3 && ev) begin
        m_valid <= 1'b0;
        if (acc_mode) begin
          m_a <= m_res; m_b <= data_in; m_op <= op; m_phase <= 2;
        end else begin
          m_a <= data_in; m_phase <= 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model_op_a", 32'(op_a), 32'(m_a));
      chk("model_op_b", 32'(op_b), 32'(m_b));
      chk("model_result", 32'(result), 32'(m_res));
      chk("model_carry", 32'(carry), 32'(m_c));
      chk("model_overflow", 32'(overflow), 32'(m_v));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_state", 32'(state), 32'(m_phase));
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_load(input logic [W-1:0] v);
    @(negedge clock);
    data_in = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Captures A then B and returns on the negedge where the result is shown.
  task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    acc_mode = 1'b0;
    pulse_load(a);
    op = o;
    pulse_load(b);
    @(negedge clock);
  endtask

  task automatic expect8(input string name, input logic [W-1:0] r, input logic c,
                         input logic v, input logic vl, input logic [1:0] st);
    chk({name, "_result"}, 32'(result), 32'(r));
    chk({name, "_carry"}, 32'(carry), 32'(c));
    chk({name, "_overflow"}, 32'(overflow), 32'(v));
    chk({name, "_valid"}, 32'(valid), 32'(vl));
    chk({name, "_state"}, 32'(state), 32'(st));
  endtask

  task automatic pulse16(input logic [15:0] v);
    @(negedge clock);
    data16 = v;
    load16 = 1'b1;
    @(negedge clock);
    load16 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(posedge clock);
    cmp_en = 1'b1;
    @(negedge clock);
    expect8("reset", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("reset_op_a", 32'(op_a), 32'h0);
    #2 resetn = 1'b1;

    calc(8'h3C, 8'h15, 1'b0);
    expect8("add_basic", 8'h51, 1'b0, 1'b0, 1'b1, 2'b11);
    calc(8'hFF, 8'h01, 1'b0);
    expect8("add_carry", 8'h00, 1'b1, 1'b0, 1'b1, 2'b11);
    calc(8'h7F, 8'h01, 1'b0);
    expect8("add_ovf", 8'h80, 1'b0, 1'b1, 1'b1, 2'b11);
    calc(8'h05, 8'h07, 1'b1);
    expect8("sub_borrow", 8'hFE, 1'b0, 1'b0, 1'b1, 2'b11);
    calc(8'h80, 8'h01, 1'b1);
    expect8("sub_ovf", 8'h7F, 1'b1, 1'b1, 1'b1, 2'b11);

    calc(8'h10, 8'h20, 1'b0);
    expect8("acc_start", 8'h30, 1'b0, 1'b0, 1'b1, 2'b11);
    acc_mode = 1'b1; op = 1'b0;
    pulse_load(8'h05);
    @(negedge clock);
    expect8("acc_add", 8'h35, 1'b0, 1'b0, 1'b1, 2'b11);
    chk("acc_add_op_a", 32'(op_a), 32'h30);
    op = 1'b1;
    pulse_load(8'h01);
    @(negedge clock);
    expect8("acc_sub", 8'h34, 1'b1, 1'b0, 1'b1, 2'b11);
    acc_mode = 1'b0;
    pulse_load(8'h99);
    chk("acc_exit_op_a", 32'(op_a), 32'h99);
    chk("acc_exit_valid", 32'(valid), 32'h0);
    chk("acc_exit_state", 32'(state), 32'h1);

    // Load held high for 10 cycles in S_A, data changed while held.
    @(negedge clock); #2 resetn = 1'b0;
    @(negedge clock); #2 resetn = 1'b1;
    @(negedge clock);
    data_in = 8'h42; load = 1'b1;
    @(negedge clock);
    data_in = 8'h55;
    repeat (9) @(negedge clock);
    load = 1'b0;
    chk("hold_state", 32'(state), 32'h1);
    chk("hold_op_a", 32'(op_a), 32'h42);

    // Load held through reset release.
    @(negedge clock); load = 1'b1; #2 resetn = 1'b0;
    @(negedge clock); #2 resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("load_thru_reset_state", 32'(state), 32'h0);
    load = 1'b0;

    // Reset during S_EXEC.
    pulse_load(8'h11);
    @(negedge clock);
    data_in = 8'h22; op = 1'b0; load = 1'b1;
    @(negedge clock);
    chk("pre_abort_state", 32'(state), 32'h2);
    #2 resetn = 1'b0; load = 1'b0;
    @(negedge clock);
    expect8("abort", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("abort_op_a", 32'(op_a), 32'h0);
    chk("abort_op_b", 32'(op_b), 32'h0);
    #2 resetn = 1'b1;
    repeat (3) @(negedge clock);
    expect8("after_abort", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

    // WIDTH = 16 instance.
    pulse16(16'hFFFF);
    op16 = 1'b0;
    pulse16(16'h0001);
    @(negedge clock);
    chk("w16_add_result", 32'(result16), 32'h0000);
    chk("w16_add_carry", 32'(carry16), 32'h1);
    chk("w16_add_overflow", 32'(overflow16), 32'h0);
    chk("w16_add_valid", 32'(valid16), 32'h1);
    pulse16(16'h8000);
    op16 = 1'b1;
    pulse16(16'h0001);
    @(negedge clock);
    chk("w16_sub_result", 32'(result16), 32'h7FFF);
    chk("w16_sub_carry", 32'(carry16), 32'h1);
    chk("w16_sub_overflow", 32'(overflow16), 32'h1);
    chk("w16_sub_state", 32'(state16), 32'h3);

    repeat (2) @(negedge clock);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
